// File: rtl/rf_pkg.sv
// Purpose : shared register-file write-back widths, the zero-register index and the write record type.
// Latency : none, declarations only.
// Backpressure: none, declarations only.
package rf_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = '0;

    // One pending register-file write, as held in the write-back output stage.
    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rr_arb2.sv
// Purpose : combinational two-way grant between A and B; round-robin when RF_WB_ARB_RR_EN is defined, else A has fixed priority.
// Latency : zero cycles, purely combinational.
// Backpressure: none here; the caller masks the grant with its own accept condition.
module rr_arb2
    import rf_pkg::*;
(
    input  logic a_valid,
    input  logic b_valid,
`ifdef RF_WB_ARB_RR_EN
    input  logic last_grant,
`endif
    output logic grant_a,
    output logic grant_b
);

`ifdef RF_WB_ARB_RR_EN
    // A tie goes to whoever did not win the previous transfer (last_grant: 0 = A, 1 = B).
    assign grant_a = a_valid && (!b_valid || last_grant);
    assign grant_b = b_valid && (!a_valid || !last_grant);
`else
    // A always wins when it is valid; B only gets the gaps in A's traffic.
    assign grant_a = a_valid;
    assign grant_b = b_valid && !a_valid;
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Purpose : arbitrate ALU (A) and load (B) results onto the single register-file write port; RF_WB_ARB_RR_EN selects round-robin over fixed priority.
// Latency : one cycle from a valid/ready transfer to RegWrite; one write per cycle when unstalled.
// Backpressure: wb_stall holds the output stage and drops both readies; the held write is issued in the first unstalled cycle.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = RF_DATA_W,
    parameter int ADDR_W  = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              wb_stall,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] RD_Address,
    output logic [DATA_W-1:0] RDdata
);

    logic               accept;
    logic [NUM_REQ-1:0] grant;     // bit 0 = A, bit 1 = B
    rf_wr_t             out_q;

    // Nothing is taken while reset is held or the write stage is frozen.
    assign accept = rst_n && !wb_stall;

`ifdef RF_WB_ARB_RR_EN
    logic last_grant;

    // Remember the most recent winner; reset to B so A wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (a_ready || b_ready) begin
            last_grant <= b_ready;
        end
    end
`endif

    rr_arb2 u_arb (
        .a_valid    (a_valid),
        .b_valid    (b_valid),
`ifdef RF_WB_ARB_RR_EN
        .last_grant (last_grant),
`endif
        .grant_a    (grant[0]),
        .grant_b    (grant[1])
    );

    assign a_ready = accept && grant[0];
    assign b_ready = accept && grant[1];

    // Output stage: load the winner, bubble when idle, hold while stalled, clear on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
        end else if (!wb_stall) begin
            if (a_ready) begin
                out_q <= '{valid: 1'b1, addr: a_addr, data: a_data};
            end else if (b_ready) begin
                out_q <= '{valid: 1'b1, addr: b_addr, data: b_data};
            end else begin
                out_q.valid <= 1'b0;
            end
        end
    end

    // Writes to the zero register are accepted upstream but never reach the register file.
    assign RegWrite   = out_q.valid && !wb_stall && (out_q.addr != RF_ZERO_REG);
    assign RD_Address = out_q.addr;
    assign RDdata     = out_q.data;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Purpose : self-checking bench for rf_wb_arbiter (both builds, selected by RF_WB_ARB_RR_EN).
// Latency : inputs change on the falling edge, outputs are sampled 1 time unit later, state moves on the rising edge.
// Backpressure: stimulus holds addr/data while valid and not ready.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid, wb_stall;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, RegWrite;
    logic [4:0]  RD_Address;
    logic [31:0] RDdata;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] rf_dut [32];
    logic [31:0] rf_mdl [32];
    logic        s_ar, s_br, s_rw;
    logic [4:0]  s_addr;
    logic [31:0] s_data;

    typedef struct {
        logic        st;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        ear;
        logic        ebr;
        logic        erw;
        logic        ca;
        logic [4:0]  eaddr;
        logic [31:0] edata;
    } vec_t;

    vec_t tbl [11];

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_valid    (a_valid),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .wb_stall   (wb_stall),
        .RegWrite   (RegWrite),
        .RD_Address (RD_Address),
        .RDdata     (RDdata)
    );

    function automatic vec_t mk(input logic st, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                                input logic ear, input logic ebr, input logic erw, input logic ca,
                                input logic [4:0] eaddr, input logic [31:0] edata);
        vec_t v;
        v.st = st; v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
        v.ear = ear; v.ebr = ebr; v.erw = erw; v.ca = ca; v.eaddr = eaddr; v.edata = edata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic st, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        wb_stall = st;
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    // Called on a falling edge with inputs set: sample, let the bench's register file capture, move to next falling edge.
    task automatic tick();
        #1;
        s_ar = a_ready; s_br = b_ready; s_rw = RegWrite; s_addr = RD_Address; s_data = RDdata;
        if (s_rw === 1'b1) rf_dut[s_addr] = s_data;
        @(negedge clk);
    endtask

    initial begin
        logic [4:0]  w_addr [8];
        logic [31:0] w_data [8];
        logic [4:0]  x_addr [4];
        logic [31:0] x_data [4];
        int          n_w, n_bready;
        logic [31:0] ka, kb;
        logic [36:0] pend_q [$];
        logic        a_pend, b_pend, mdl_last;

        for (int i = 0; i < 32; i++) rf_dut[i] = '0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // Reset held 3 cycles with A requesting.
        drive(0, 1, 5'd5, 32'h1234, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_a_ready", {31'b0, s_ar}, 0);
            chk("reset_b_ready", {31'b0, s_br}, 0);
            if (i > 0) begin
                chk("reset_regwrite", {31'b0, s_rw}, 0);
                chk("reset_rd_address", {27'b0, s_addr}, 0);
                chk("reset_rddata", s_data, 0);
            end
        end
        rst_n = 1'b1;

        // Directed table: single write, zero register, stall, contention under stall.
        tbl[0] = mk(0, 1, 5'd5, 32'h1234, 0, 5'd0, 32'h0,     1, 0, 0, 0, 5'd0, 32'h0);
        tbl[1] = mk(0, 0, 5'd0, 32'h0,    1, 5'd0, 32'hFFFF,  0, 1, 1, 1, 5'd5, 32'h1234);
        tbl[2] = mk(0, 1, 5'd9, 32'h55,   0, 5'd0, 32'h0,     1, 0, 0, 0, 5'd0, 32'h0);
        tbl[3] = mk(1, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,     0, 0, 0, 1, 5'd9, 32'h55);
        tbl[4] = mk(1, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,     0, 0, 0, 1, 5'd9, 32'h55);
        tbl[5] = mk(0, 0, 5'd0, 32'h0,    1, 5'd7, 32'hBB,    0, 1, 1, 1, 5'd9, 32'h55);
        tbl[6] = mk(1, 1, 5'd3, 32'hAA,   1, 5'd7, 32'hCC,    0, 0, 0, 1, 5'd7, 32'hBB);
        tbl[7] = mk(0, 1, 5'd3, 32'hAA,   1, 5'd7, 32'hCC,    1, 0, 1, 1, 5'd7, 32'hBB);
`ifdef RF_WB_ARB_RR_EN
        tbl[8] = mk(0, 1, 5'd4, 32'h11,   1, 5'd7, 32'hCC,    0, 1, 1, 1, 5'd3, 32'hAA);
        tbl[9] = mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,     0, 0, 1, 1, 5'd7, 32'hCC);
`else
        tbl[8] = mk(0, 1, 5'd4, 32'h11,   1, 5'd7, 32'hCC,    1, 0, 1, 1, 5'd3, 32'hAA);
        tbl[9] = mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,     0, 0, 1, 1, 5'd4, 32'h11);
`endif
        tbl[10] = mk(0, 0, 5'd0, 32'h0,   0, 5'd0, 32'h0,     0, 0, 0, 0, 5'd0, 32'h0);

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].st, tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd);
            tick();
            chk($sformatf("tbl%0d_a_ready", i), {31'b0, s_ar}, {31'b0, tbl[i].ear});
            chk($sformatf("tbl%0d_b_ready", i), {31'b0, s_br}, {31'b0, tbl[i].ebr});
            chk($sformatf("tbl%0d_regwrite", i), {31'b0, s_rw}, {31'b0, tbl[i].erw});
            if (tbl[i].ca) begin
                chk($sformatf("tbl%0d_rd_address", i), {27'b0, s_addr}, {27'b0, tbl[i].eaddr});
                chk($sformatf("tbl%0d_rddata", i), s_data, tbl[i].edata);
            end
        end
        chk("rf_reg0_reads_zero", rf_dut[0], 32'h0);
        chk("rf_reg5_after_write", rf_dut[5], 32'h1234);
        chk("rf_reg9_after_stall", rf_dut[9], 32'h55);

        // Contention: both valid for 4 cycles, each side advances its value only when accepted.
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        ka = 32'hAA; kb = 32'hBB; n_w = 0; n_bready = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(0, 1, 5'd3, ka, 1, 5'd7, kb);
            else       drive(0, 0, 0, 0, 0, 0, 0);
            tick();
            if (s_ar === 1'b1) ka++;
            if (s_br === 1'b1) begin kb++; n_bready++; end
            if (s_rw === 1'b1 && n_w < 8) begin
                w_addr[n_w] = s_addr; w_data[n_w] = s_data; n_w++;
            end
        end
`ifdef RF_WB_ARB_RR_EN
        x_addr = '{5'd3, 5'd7, 5'd3, 5'd7};
        x_data = '{32'hAA, 32'hBB, 32'hAB, 32'hBC};
        chk("contention_b_ready_count", n_bready, 2);
`else
        x_addr = '{5'd3, 5'd3, 5'd3, 5'd3};
        x_data = '{32'hAA, 32'hAB, 32'hAC, 32'hAD};
        chk("contention_b_ready_count", n_bready, 0);
`endif
        chk("contention_write_count", n_w, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < n_w) begin
                chk($sformatf("contention_w%0d_addr", i), {27'b0, w_addr[i]}, {27'b0, x_addr[i]});
                chk($sformatf("contention_w%0d_data", i), w_data[i], x_data[i]);
            end
        end

        // Reset while a write is stalled: the held write is lost, register 4 keeps its earlier value.
        drive(0, 1, 5'd4, 32'h33, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0);         tick();
        chk("midstall_first_write_lands", rf_dut[4], 32'h33);
        drive(0, 1, 5'd4, 32'h77, 0, 0, 0); tick();
        chk("midstall_transfer_ready", {31'b0, s_ar}, 1);
        drive(1, 0, 0, 0, 0, 0, 0);         tick();
        chk("midstall_stalled_regwrite", {31'b0, s_rw}, 0);
        chk("midstall_stalled_addr", {27'b0, s_addr}, 4);
        rst_n = 1'b0;                       tick();
        chk("midstall_reset_regwrite", {31'b0, s_rw}, 0);
        rst_n = 1'b1; wb_stall = 1'b0;      tick();
        chk("midstall_after_reset_regwrite", {31'b0, s_rw}, 0);
        tick();
        chk("midstall_idle_regwrite", {31'b0, s_rw}, 0);
        chk("midstall_reg4_kept", rf_dut[4], 32'h33);

        // Random traffic against a transaction-level model: a queue of at most one accepted write.
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin rf_dut[i] = '0; rf_mdl[i] = '0; end
        pend_q.delete();
        mdl_last = 1'b1;
        a_pend = 1'b0; b_pend = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic ga, gb, erw;
            if (!a_pend) begin
                a_valid = ($urandom_range(0, 3) != 0); a_addr = 5'($urandom); a_data = $urandom;
            end
            if (!b_pend) begin
                b_valid = ($urandom_range(0, 2) != 0); b_addr = 5'($urandom); b_data = $urandom;
            end
            wb_stall = ($urandom_range(0, 4) == 0);
            rst_n = ($urandom_range(0, 50) != 0);
            ga = 1'b0; gb = 1'b0;
            if (rst_n && !wb_stall) begin
                if (a_valid && b_valid) begin
`ifdef RF_WB_ARB_RR_EN
                    if (mdl_last) ga = 1'b1; else gb = 1'b1;
`else
                    ga = 1'b1;
`endif
                end else begin
                    ga = a_valid; gb = b_valid;
                end
            end
            erw = (pend_q.size() != 0) && !wb_stall && (pend_q[0][36:32] != 5'd0);
            tick();
            chk("rand_a_ready", {31'b0, s_ar}, {31'b0, ga});
            chk("rand_b_ready", {31'b0, s_br}, {31'b0, gb});
            chk("rand_regwrite", {31'b0, s_rw}, {31'b0, erw});
            if (pend_q.size() != 0) begin
                chk("rand_rd_address", {27'b0, s_addr}, {27'b0, pend_q[0][36:32]});
                chk("rand_rddata", s_data, pend_q[0][31:0]);
            end
            if (erw) rf_mdl[pend_q[0][36:32]] = pend_q[0][31:0];
            if (!rst_n) begin
                pend_q.delete();
                mdl_last = 1'b1;
            end else if (!wb_stall) begin
                pend_q.delete();
                if (ga) begin pend_q.push_back({a_addr, a_data}); mdl_last = 1'b0; end
                else if (gb) begin pend_q.push_back({b_addr, b_data}); mdl_last = 1'b1; end
            end
            a_pend = a_valid && !ga;
            b_pend = b_valid && !gb;
        end
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("rand_rf_reg%0d", i), rf_dut[i], rf_mdl[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter for the 32x32 register file's single write port. Two requesters, A (ALU result) and B (load data), each present a destination register and a 32-bit value with a valid/ready handshake. The block picks one per cycle, registers it, and drives the register file's `RegWrite` / `RD_Address` / `RDdata` inputs. A stall input freezes the write stage without losing the held write.

## Interface
- `NUM_REQ`, 2: requester count; fixed, not generalised.
- `DATA_W`, 32: write-data width, matching the register file word.
- `ADDR_W`, 5: register index width (32 registers).
- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `a_valid`  in  1  requester A has a write pending.
- `a_addr`  in  ADDR_W  A destination register.
- `a_data`  in  DATA_W  A write value.
- `a_ready`  out  1  A's write accepted this cycle.
- `b_valid`, `b_addr`, `b_data`, `b_ready`: same meaning as A, for requester B.
- `wb_stall`  in  1  hold the write stage; no register file write this cycle.
- `RegWrite`  out  1  register file write enable.
- `RD_Address`  out  ADDR_W  register file write index.
- `RDdata`  out  DATA_W  register file write data.

## Operation
- State:
  - output stage `out_valid`, `out_addr`, `out_data`;
  - `last_grant` (0 = A, 1 = B).
- `accept = rst_n && !wb_stall`.
- Grant:
  - Only one valid requester: that requester is granted.
  - Both valid: the one not equal to `last_grant` is granted.
  - Neither valid: no grant.
- `a_ready = accept && grant==A`; `b_ready = accept && grant==B`. Ready is a combinational function of valid, stall and `last_grant`.
- Handshake:
  - A transfer occurs when valid && ready.
  - Requesters hold addr/data stable while valid && !ready.
  - Valid does not depend on ready.
- On a transfer, the output stage loads `{1, addr, data}`.
- If `accept` is high and no transfer occurs, the output stage loads `out_valid=0` (bubble).
- On a transfer, `last_grant` updates to the granted requester.
- While `wb_stall=1`, the output stage and `last_grant` hold.
- `RegWrite = out_valid && !wb_stall && out_addr!=0`. Writes to register 0 are accepted and silently dropped.
- `RD_Address = out_addr`; `RDdata = out_data`. Both stay valid whether or not `RegWrite` is high.
- Both requesters targeting the same register: they are serialised in grant order, so the later grant's data ends in the register.

## Timing
- Reset (`rst_n=0` at posedge):
  - `out_valid=0`, `out_addr=0`, `out_data=0`, `last_grant=1`, so A wins the first tie.
  - Outputs after the reset edge: `RegWrite=0`, `RD_Address=0`, `RDdata=0`, `a_ready=b_ready=0`.
- Reset mid-operation discards any held write. No register file write occurs in the cycle after the reset edge.
- Latency: a transfer in cycle N drives `RegWrite` in cycle N+1. The register file captures the write at the end of N+1.
- Throughput: one write per cycle when unstalled.
- Both valid continuously: grants alternate A, B, A, B…
- Stall:
  - A stall in cycle N+1 defers the write, which appears in the first unstalled cycle.
  - In that cycle the write occurs and a new transfer is accepted.
- Stall asserted while both requesters are valid: no ready, and no change to arbitration order.

## Configuration
- `RF_WB_ARB_RR_EN` defined: round-robin as described above.
- Undefined: fixed priority. A always wins when valid, and `last_grant` is not implemented. B can starve; the system must guarantee gaps in A's traffic.
- All other behaviour is identical in both builds.

## Structure
- Shared package `rf_pkg` holds:
  - `RF_ADDR_W=5`, `RF_DATA_W=32`, `RF_ZERO_REG=0`;
  - typedef `rf_wr_t` (`valid`, `addr`, `data`), used for the output stage.
- One sub-module: `rr_arb2`, the combinational two-way grant from `{a_valid, b_valid, last_grant}`. Its fixed-priority variant is selected by the macro.
- The output register lives in the top module.

## Test plan
- **Reset:** hold `rst_n=0` 3 cycles with `a_valid=1` → readies 0, `RegWrite=0` throughout; first post-reset cycle `a_ready=1`.
- **Single write:** A sends addr 5, data 0x1234 in cycle N → cycle N+1 `RegWrite=1`, `RD_Address=5`, `RDdata=0x1234`. Reading RS=5 afterwards returns 0x1234.
- **Contention:** A and B valid 4 cycles (A: reg 3/0xAA, B: reg 7/0xBB, held until accepted, then next values).
  - With `RF_WB_ARB_RR_EN`: writes ordered 3, 7, 3, 7.
  - Without the macro: 3, 3, 3, 3, and `b_ready` never asserts.
- **Stall:** transfer reg 9/0x55, then `wb_stall=1` for 2 cycles → `RegWrite=0` both cycles, readies 0, `RD_Address` holds 9. Write occurs in the first unstalled cycle.
- **Zero register:** B writes reg 0/0xFFFF → `b_ready=1`, next cycle `RegWrite=0`; register 0 still reads 0.
- **Reset mid-stall:** pending write reg 4/0x77 stalled, then `rst_n=0` → `RegWrite` never asserts for reg 4; register 4 keeps its prior value.
